// File: rtl/column_write_scheduler_pkg.sv
// Shared types and defaults for the column write scheduler.
package column_write_scheduler_pkg;

    localparam int NCOLS_DEF   = 100;
    localparam int DEPTH_DEF   = 4;
    localparam int TIMEOUT_DEF = 255;

    localparam int X_W  = 10;
    localparam int Y_W  = 10;
    localparam int D_W  = 8;
    localparam int PT_W = X_W + Y_W + D_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    // One queued point write, stored as {x, y, data}.
    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [D_W-1:0] data;
    } point_t;

endpackage

// File: rtl/column_write_scheduler_point_fifo.sv
// Small synchronous FIFO holding pending point writes; head is visible combinationally.
module point_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 28
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    // DEPTH is a power of two, so the pointers wrap naturally.
    assign pop_data = mem[rd_ptr];
    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);

    // Storage array: written on push, no reset needed.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // Pointers and occupancy; simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/column_write_scheduler.sv
// Serialises queued point writes onto one-hot column strobes, waiting for each column's ack.
module column_write_scheduler
    import column_write_scheduler_pkg::*;
#(
    parameter int NCOLS   = NCOLS_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [X_W-1:0]   req_x,
    input  logic [Y_W-1:0]   req_y,
    input  logic [D_W-1:0]   req_data,
    output logic [NCOLS-1:0] col_select,
    output logic [Y_W-1:0]   row_select,
    output logic [D_W-1:0]   col_data,
    input  logic [NCOLS-1:0] return_sig,
    output logic             busy,
    output logic             err_range,
    output logic             err_timeout,
    output logic [15:0]      done_count
);

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    state_e           state_q, state_d;
    logic [NCOLS-1:0] cs_q, cs_d;
    logic [Y_W-1:0]   row_q, row_d;
    logic [D_W-1:0]   data_q, data_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [15:0]      done_cnt_q, done_cnt_d;
    logic             erng_q, erng_d, eto_q, eto_d;
    logic             rdy_en_q;

    point_t req_pt, head;
    logic   push, pop, full, empty, in_range, ack;

    assign req_pt    = '{x: req_x, y: req_y, data: req_data};
    // rdy_en_q keeps req_ready low through reset and for the edge that releases it.
    assign req_ready = rdy_en_q & ~full;
    assign push      = req_valid & req_ready;
    assign in_range  = ({22'd0, head.x} < 32'(NCOLS));
    // The strobe register already holds one-hot(latched x), so masking with it
    // both selects the right acknowledge and ignores every other column.
    assign ack       = |(return_sig & cs_q);

    point_fifo #(.DEPTH(DEPTH), .W(PT_W)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (req_pt),
        .pop       (pop),
        .pop_data  (head),
        .full      (full),
        .empty     (empty)
    );

    assign col_select  = cs_q;
    assign row_select  = row_q;
    assign col_data    = data_q;
    assign busy        = ~empty | (state_q != ST_IDLE);
    assign err_range   = erng_q;
    assign err_timeout = eto_q;
    assign done_count  = done_cnt_q;

    // Next-state and datapath updates: issue from IDLE, ack/timeout in WAIT, one-cycle RELEASE gap.
    always_comb begin
        state_d    = state_q;
        cs_d       = cs_q;
        row_d      = row_q;
        data_d     = data_q;
        tmr_d      = tmr_q;
        done_cnt_d = done_cnt_q;
        erng_d     = erng_q;
        eto_d      = eto_q;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (in_range) begin
                        cs_d    = NCOLS'(1) << head.x;
                        row_d   = head.y;
                        data_d  = head.data;
                        tmr_d   = '0;
                        state_d = ST_WAIT;
                    end else begin
                        erng_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (ack) begin
                    cs_d       = '0;
                    done_cnt_d = done_cnt_q + 16'd1;
                    state_d    = ST_RELEASE;
                end else if (tmr_q == TMAX) begin
                    cs_d    = '0;
                    eto_d   = 1'b1;
                    state_d = ST_RELEASE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset drops everything in flight immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cs_q       <= '0;
            row_q      <= '0;
            data_q     <= '0;
            tmr_q      <= '0;
            done_cnt_q <= '0;
            erng_q     <= 1'b0;
            eto_q      <= 1'b0;
            rdy_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cs_q       <= cs_d;
            row_q      <= row_d;
            data_q     <= data_d;
            tmr_q      <= tmr_d;
            done_cnt_q <= done_cnt_d;
            erng_q     <= erng_d;
            eto_q      <= eto_d;
            rdy_en_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_column_write_scheduler.sv
// Scoreboard bench: accepted requests queue their expected strobe; a monitor pops and compares on issue.
module tb_column_write_scheduler;
    import column_write_scheduler_pkg::*;

    localparam int NC = 100;
    localparam int DP = 4;
    localparam int TO = 255;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [X_W-1:0]  req_x = '0;
    logic [Y_W-1:0]  req_y = '0;
    logic [D_W-1:0]  req_data = '0;
    logic [NC-1:0]   col_select;
    logic [Y_W-1:0]  row_select;
    logic [D_W-1:0]  col_data;
    logic [NC-1:0]   return_sig = '0;
    logic            busy, err_range, err_timeout;
    logic [15:0]     done_count;

    always #5 clock = ~clock;

    column_write_scheduler #(.NCOLS(NC), .DEPTH(DP), .TIMEOUT(TO)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_data    (req_data),
        .col_select  (col_select),
        .row_select  (row_select),
        .col_data    (col_data),
        .return_sig  (return_sig),
        .busy        (busy),
        .err_range   (err_range),
        .err_timeout (err_timeout),
        .done_count  (done_count)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [NC-1:0] onehot(input int i);
        logic [NC-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Scoreboard and column model state.
    point_t        exp_q[$];
    int            ack_dly   = 0;   // strobe cycles before the column acks; -1 = never
    logic [NC-1:0] stray     = '0;  // unrelated return bits held high
    int            hi_cnt    = 0;
    int            last_len  = 0;
    int            n_issued  = 0;
    bit            gap_chk   = 0;
    logic [NC-1:0] prev_cs   = '0;

    // Monitor + column model, sampled on the falling edge.
    initial begin
        point_t e;
        forever begin
            @(negedge clock);
            if (gap_chk) begin
                check("release_gap", col_select, '0);
                gap_chk = 0;
            end
            if (col_select != '0 && prev_cs == '0) begin
                hi_cnt = 0;
                if (exp_q.size() == 0) begin
                    check("spurious_issue", col_select, '0);
                end else begin
                    e = exp_q.pop_front();
                    check("issue_cs", col_select, onehot(int'(e.x)));
                    check("issue_row", row_select, e.y);
                    check("issue_data", col_data, e.data);
                    n_issued++;
                end
            end else if (col_select != '0) begin
                check("cs_stable", col_select, prev_cs);
            end
            if (col_select != '0) hi_cnt++;
            if (col_select == '0 && prev_cs != '0) begin
                last_len = hi_cnt;
                gap_chk  = 1;
            end
            return_sig = stray |
                ((ack_dly >= 0 && hi_cnt >= ack_dly + 1 && col_select != '0) ? col_select : '0);
            prev_cs = col_select;
        end
    end

    // Offer one request starting at a falling edge; returns whether it had to stall first.
    task automatic push(input int x, input int y, input int d, output bit stalled);
        bit ok = 0;
        point_t p;
        stalled   = 0;
        req_valid = 1'b1;
        req_x     = X_W'(x);
        req_y     = Y_W'(y);
        req_data  = D_W'(d);
        for (int c = 0; c < 2000; c++) begin
            if (req_ready) begin
                @(posedge clock);
                ok = 1;
                break;
            end
            stalled = 1;
            @(negedge clock);
        end
        if (!ok) check("push_timeout", 0, 1);
        else if (x < NC) begin
            p = '{x: X_W'(x), y: Y_W'(y), data: D_W'(d)};
            exp_q.push_back(p);
        end
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            if (!busy && col_select == '0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 0, 1);
        repeat (2) @(negedge clock);
    endtask

    // Assert reset mid-cycle (asynchronously), check cleared outputs, then release.
    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        check("rst_cs", col_select, '0);
        check("rst_row", row_select, '0);
        check("rst_data", col_data, '0);
        check("rst_done", done_count, '0);
        check("rst_erng", err_range, 0);
        check("rst_eto", err_timeout, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 0);
        exp_q.delete();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1 check("ready_low_before_edge", req_ready, 0);
        @(posedge clock);
        #1 check("ready_after_edge", req_ready, 1);
        @(negedge clock);
    endtask

    initial begin
        bit st;
        int acc, stall_at, base;

        // Power-on reset.
        @(negedge clock);
        do_reset();

        // Single write, ack after 2 strobe cycles: 3-cycle strobe, data -3 -> FD.
        ack_dly = 2;
        push(5, 17, -3, st);
        wait_idle();
        check("t1_len", last_len, 3);
        check("t1_done", done_count, 1);
        check("t1_issued", n_issued, 1);

        // Six back-to-back with slow acks: the first is popped into service at once,
        // so the FIFO fills (ready drops) on the request after DEPTH+1 are accepted.
        do_reset();
        ack_dly  = 10;
        base     = n_issued;
        acc      = 0;
        stall_at = -1;
        for (int i = 0; i < 6; i++) begin
            push(10 + i, i, 3 * i + 1, st);
            if (st && stall_at < 0) stall_at = acc;
            acc++;
        end
        wait_idle();
        check("t2_stall_at", stall_at, DP + 1);
        check("t2_issued", n_issued - base, 6);
        check("t2_done", done_count, 6);
        check("t2_q_empty", exp_q.size(), 0);

        // Out-of-range x is dropped with err_range, next request still issues.
        do_reset();
        ack_dly = 0;
        base    = n_issued;
        push(120, 1, 1, st);
        push(3, 2, 2, st);
        wait_idle();
        check("t3_erng", err_range, 1);
        check("t3_issued", n_issued - base, 1);
        check("t3_done", done_count, 1);
        check("t3_len", last_len, 1);

        // No ack: strobe lasts TIMEOUT+1 cycles, err_timeout sticks.
        do_reset();
        ack_dly = -1;
        push(7, 9, 33, st);
        wait_idle();
        check("t4_len", last_len, TO + 1);
        check("t4_eto", err_timeout, 1);
        check("t4_done", done_count, 0);
        ack_dly = 0;
        push(8, 1, 1, st);
        wait_idle();
        check("t4_eto_sticky", err_timeout, 1);
        check("t4_done2", done_count, 1);

        // Stray return bit 9 must not ack column 4; then reset mid-WAIT.
        do_reset();
        stray   = onehot(9);
        ack_dly = 3;
        push(4, 5, 6, st);
        wait_idle();
        check("t5_len", last_len, 4);
        check("t5_done", done_count, 1);
        ack_dly = -1;
        push(4, 8, 9, st);
        push(6, 1, 1, st);
        push(7, 1, 1, st);
        repeat (3) @(negedge clock);
        check("t5_wait_cs", col_select, onehot(4));
        base = n_issued;
        do_reset();
        stray = '0;
        repeat (20) @(negedge clock);
        check("t5_busy_after", busy, 0);
        check("t5_no_reissue", n_issued - base, 0);

        // done_count wrap: preload 0xFFFF, one more ack wraps to 0.
        do_reset();
        ack_dly = 0;
        force dut.done_cnt_q = 16'hFFFF;
        #1 release dut.done_cnt_q;
        push(1, 2, 3, st);
        wait_idle();
        check("t6_wrap", done_count, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
